maple_port_scheduler: RTL and testbench

- Round-robin scheduler that shares the single Maple PHY/output engine among four port requesters.
- Grants one port at a time and drives the 2-bit port select to the physical port mux.
- Sequences each transaction: transmit start/complete handshake, then a receive window bounded by a tick-based timeout.
- Reports completion or timeout per transaction and sits between the register/FIFO front end and the maple_ports/maple_out datapath.

---
 rtl/maple_port_scheduler.sv | 140 ++++++++++++++
 tb/tb_maple_port_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maple_port_scheduler.sv
// maple_port_scheduler
//   Shares the single Maple PHY/output engine among four port requesters.
//   A round-robin arbiter grants one port at a time. The scheduler then drives
//   the port mux select and sequences the transaction: a transmit start/complete
//   handshake with the output engine, followed by a receive window that is
//   bounded by a tick-based timeout.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   tick            one-cycle strobe from clock_divider, the timeout time base
//   req[3:0]        per-port request level (bit n = port n), sampled in IDLE only
//   timeout_ticks   receive window length in ticks (0 = no timeout)
//   tx_start        asks the output engine to send the FIFO frame
//   tx_busy         output engine send in progress
//   rx_enable       receiver armed for the granted port
//   rx_done         receiver captured end of frame (one-cycle pulse)
//   port_select     physical port index for maple_ports
//   grant[3:0]      one-hot grant, zero when no port is active
//   busy            high in every state except IDLE
//   xfer_done       one-cycle pulse at transaction end
//   xfer_timeout    qualified by xfer_done: 1 = timed out, 0 = rx_done
module maple_port_scheduler #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [3:0]           req,
  input  logic [TIMEOUT_W-1:0] timeout_ticks,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 rx_enable,
  input  logic                 rx_done,
  output logic [1:0]           port_select,
  output logic [3:0]           grant,
  output logic                 busy,
  output logic                 xfer_done,
  output logic                 xfer_timeout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    TX_REQ  = 3'd2,
    TX_WAIT = 3'd3,
    RX_WAIT = 3'd4,
    RELEASE = 3'd5
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic   [1:0]           rr_ptr;
  logic   [1:0]           port_sel;
  logic   [1:0]           win;
  logic                   win_vld;
  logic   [1:0]           scan_idx;
  logic   [TIMEOUT_W-1:0] tick_cnt;
  logic                   to_hit;
  logic                   to_flag;

  // Round-robin scan: walk from the highest offset down, so the lowest offset
  // from rr_ptr (the first requester in wrap order) is the one that sticks.
  always_comb begin
    win      = 2'd0;
    win_vld  = 1'b0;
    scan_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      scan_idx = rr_ptr + 2'(i);
      if (req[scan_idx]) begin
        win     = scan_idx;
        win_vld = 1'b1;
      end
    end
  end

  // The terminating tick is the timeout_ticks-th tick seen in RX_WAIT.
  assign to_hit = (timeout_ticks != '0) && tick &&
                  (tick_cnt == (timeout_ticks - TIMEOUT_W'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_vld) state_nxt = SELECT;
      SELECT:  state_nxt = TX_REQ;
      TX_REQ:  if (tx_busy) state_nxt = TX_WAIT;
      TX_WAIT: if (!tx_busy) state_nxt = RX_WAIT;
      RX_WAIT: if (rx_done || to_hit) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Port select, round-robin pointer, receive tick counter and end cause
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= 2'd0;
      port_sel <= 2'd0;
      tick_cnt <= '0;
      to_flag  <= 1'b0;
    end else begin
      if (state == IDLE && win_vld) port_sel <= win;

      // A tick in the cycle that leaves TX_WAIT is deliberately not counted.
      if (state == TX_WAIT && !tx_busy) begin
        tick_cnt <= '0;
      end else if (state == RX_WAIT && !rx_done && !to_hit && tick &&
                   tick_cnt != '1) begin
        tick_cnt <= tick_cnt + TIMEOUT_W'(1);
      end

      // rx_done outranks a coincident terminating tick.
      if (state == RX_WAIT && (rx_done || to_hit)) to_flag <= !rx_done;

      if (state == RELEASE) rr_ptr <= port_sel + 2'd1;
    end
  end

  // Output logic
  always_comb begin
    tx_start     = (state == TX_REQ);
    rx_enable    = (state == RX_WAIT);
    busy         = (state != IDLE);
    xfer_done    = (state == RELEASE);
    xfer_timeout = (state == RELEASE) && to_flag;
    port_select  = port_sel;
    grant        = 4'b0000;
    if (state == SELECT || state == TX_REQ || state == TX_WAIT ||
        state == RX_WAIT) begin
      grant = 4'b0001 << port_sel;
    end
  end

endmodule

// File: tb/tb_maple_port_scheduler.sv
module tb_maple_port_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [15:0] timeout_ticks = 16'd0;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        rx_enable;
  logic        rx_done = 1'b0;
  logic [1:0]  port_select;
  logic [3:0]  grant;
  logic        busy;
  logic        xfer_done;
  logic        xfer_timeout;

  maple_port_scheduler #(.TIMEOUT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .req          (req),
    .timeout_ticks(timeout_ticks),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .rx_enable    (rx_enable),
    .rx_done      (rx_done),
    .port_select  (port_select),
    .grant        (grant),
    .busy         (busy),
    .xfer_done    (xfer_done),
    .xfer_timeout (xfer_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard queues: expected grant port and grant gap, expected end cause
  // and expected number of receive-window cycles.
  int gq[$];
  int gapq[$];
  int toq[$];
  int rxq[$];

  int rr_m  = 0;
  bit first = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_line(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: unexpected event at %0t", nm, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first asserted request at or after the pointer, wrapping.
  function automatic int pick(input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (r[(rr_m + i) % 4]) return (rr_m + i) % 4;
    end
    return -1;
  endfunction

  task automatic wait_tx_start();
    int n = 0;
    while (tx_start !== 1'b1) begin
      step();
      n++;
      if (n > 50) begin
        $display("FAIL tx_start_wait: no tx_start within 50 cycles");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_fail + 1);
        $fatal(1, "scheduler stalled");
      end
    end
  endtask

  // One transaction. Called at #1 after a posedge while the DUT is in RELEASE
  // or IDLE. k = extra IDLE cycles with no request; plan = receive cycle index
  // carrying rx_done (-1 = never); tper = tick period in receive cycles
  // (0 = random ticks); d1/d2 = tx_busy rise delay / high time (-1 = random).
  task automatic xfer(input logic [3:0] r, input int k, input int tt, input int plan,
                      input int tper, input int d1, input int d2, input bit drop);
    int  p, c, cnt, to, dd1, dd2;
    bit  done;
    req = 4'b0000;
    step();
    repeat (k) step();
    req           = r;
    timeout_ticks = 16'(tt);
    p             = pick(r);
    gq.push_back(p);
    gapq.push_back(first ? -1 : k + 2);
    first = 1'b0;
    rr_m  = (p + 1) % 4;
    wait_tx_start();
    if (drop) req = 4'($urandom);
    dd1 = (d1 < 0) ? int'($urandom_range(0, 2)) : d1;
    dd2 = (d2 < 0) ? int'($urandom_range(1, 4)) : d2;
    repeat (dd1) step();
    tx_busy = 1'b1;
    repeat (dd2) step();
    tx_busy = 1'b0;
    tick    = 1'($urandom_range(0, 1));
    step();
    c    = 0;
    cnt  = 0;
    to   = 0;
    done = 1'b0;
    while (!done && c < 5000) begin
      tick    = (tper > 0) ? ((c % tper) == tper - 1) : ($urandom_range(0, 2) == 0);
      rx_done = (c == plan);
      if (rx_done) begin
        done = 1'b1;
        to   = 0;
      end else if (tt != 0 && tick && cnt == tt - 1) begin
        done = 1'b1;
        to   = 1;
      end else if (tick) begin
        cnt++;
      end
      step();
      c++;
    end
    tick    = 1'b0;
    rx_done = 1'b0;
    if (!done) fail_line("rx_window_bound");
    toq.push_back(to);
    rxq.push_back(c);
  endtask

  // Monitor
  int          since = -1;
  logic [3:0]  pg    = 4'b0000;
  int          rxcnt = 0;
  bit          chk_idle = 1'b0;
  int          mp, mg, mt, mr;

  always @(negedge clk) begin
    if (rst) begin
      since    = -1;
      pg       = 4'b0000;
      rxcnt    = 0;
      chk_idle = 1'b0;
    end else begin
      if (since >= 0 && !xfer_done) since++;
      if (grant != 4'b0000 && pg == 4'b0000) begin
        if (gq.size() == 0) begin
          fail_line("unexpected_grant");
        end else begin
          mp = gq.pop_front();
          mg = gapq.pop_front();
          chk("grant", 32'(grant), 32'(4'b0001 << mp));
          chk("port_select", 32'(port_select), 32'(mp));
          if (mg >= 0) chk("grant_gap", 32'(since), 32'(mg));
        end
        rxcnt = 0;
      end
      if (grant != 4'b0000) chk("grant_matches_select", 32'(grant), 32'(4'b0001 << port_select));
      if (rx_enable) rxcnt++;
      if (xfer_done) begin
        if (toq.size() == 0) begin
          fail_line("unexpected_xfer_done");
        end else begin
          mt = toq.pop_front();
          mr = rxq.pop_front();
          chk("xfer_timeout", 32'(xfer_timeout), 32'(mt));
          chk("rx_window_cycles", 32'(rxcnt), 32'(mr));
          chk("grant_in_release", 32'(grant), 32'(0));
        end
        since    = 0;
        chk_idle = 1'b1;
      end else if (chk_idle) begin
        chk("busy_after_release", 32'(busy), 32'(0));
        chk("xfer_done_single", 32'(xfer_done), 32'(0));
        chk_idle = 1'b0;
      end
      pg = grant;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_grant"}, 32'(grant), 32'(0));
    chk({tag, "_port_select"}, 32'(port_select), 32'(0));
    chk({tag, "_tx_start"}, 32'(tx_start), 32'(0));
    chk({tag, "_rx_enable"}, 32'(rx_enable), 32'(0));
    chk({tag, "_xfer_done"}, 32'(xfer_done), 32'(0));
    chk({tag, "_xfer_timeout"}, 32'(xfer_timeout), 32'(0));
  endtask

  initial begin
    int r, k, tt, plan;
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'(0));

    // All four requesting: order 0,1,2,3,0 with one IDLE cycle between grants.
    for (int i = 0; i < 5; i++) xfer(4'b1111, 0, 0, 3, 0, -1, -1, 1'b0);

    // Single requester on port 2 with fixed handshake timing.
    xfer(4'b0100, 0, 0, 5, 0, 2, 10, 1'b0);

    // Timeout after three ticks spaced six cycles apart.
    xfer(4'b0001, 1, 3, -1, 6, -1, -1, 1'b0);

    // rx_done coincident with the terminating tick: rx_done wins.
    xfer(4'b0010, 0, 3, 5, 2, -1, -1, 1'b0);

    // Timeout disabled: 1000 ticks pass, then rx_done completes normally.
    xfer(4'b1000, 0, 0, 1000, 1, -1, -1, 1'b0);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      r    = $urandom_range(1, 15);
      k    = $urandom_range(0, 2);
      tt   = $urandom_range(0, 5);
      plan = (tt == 0 || $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1;
      xfer(4'(r), k, tt, plan, 0, -1, -1, 1'b1);
    end

    // Reset in the middle of RX_WAIT with port 1 granted.
    req = 4'b0000;
    step();
    req           = 4'b0010;
    timeout_ticks = 16'd0;
    gq.push_back(pick(4'b0010));
    gapq.push_back(-1);
    wait_tx_start();
    tx_busy = 1'b1;
    step();
    tx_busy = 1'b0;
    step();
    step();
    step();
    chk("rx_wait_rx_enable", 32'(rx_enable), 32'(1));
    chk("rx_wait_grant", 32'(grant), 32'(4'b0010));
    chk("rx_wait_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    req = 4'b0000;
    step();
    chk_all_zero("midreset");
    rst = 1'b0;
    gq.delete();
    gapq.delete();
    toq.delete();
    rxq.delete();
    rr_m  = 0;
    first = 1'b1;
    xfer(4'b0011, 0, 0, 2, 0, -1, -1, 1'b0);
    xfer(4'b0011, 0, 0, 2, 0, -1, -1, 1'b0);

    req = 4'b0000;
    repeat (5) step();
    chk("grant_queue_drained", 32'(gq.size()), 32'(0));
    chk("done_queue_drained", 32'(toq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
